// File: rtl/bcd_key_counter.sv
// Two-digit BCD up/down counter fed by raw active-low push-buttons, with sync, debounce and press detection.
// Optional auto-repeat while a key is held: define BCD_KEY_AUTOREPEAT_EN.
module bcd_key_counter #(
    parameter int DEB_CYCLES = 500000
`ifdef BCD_KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap,
    output logic       load_err
);

    localparam int CW = $clog2(DEB_CYCLES);

    // Bit 0 is the increment key, bit 1 the decrement key.
    logic [1:0]    key_raw;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    db_q, db_d;
    logic [1:0]    db_prev_q, db_prev_d;
    logic [1:0]    press_q, press_d;
    logic [1:0]    rep_fire;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          wrap_q, wrap_d;
    logic          load_err_q, load_err_d;
    logic          load_ok;
    logic          inc_ev;
    logic          dec_ev;

    assign key_raw = {key_dec_n, key_inc_n};

`ifdef BCD_KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);

    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];

    // Timer runs only once the initial press has been issued (db low for two samples).
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rep_d[k]    = '0;
            rep_fire[k] = 1'b0;
            if (!db_q[k] && !db_prev_q[k] && !load) begin
                if (rep_q[k] == RW'(REPEAT_CYCLES - 1)) begin
                    rep_fire[k] = 1'b1;
                end else begin
                    rep_d[k] = rep_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int k = 0; k < 2; k++) begin
                rep_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                rep_q[k] <= rep_d[k];
            end
        end
    end
`else
    assign rep_fire = 2'b00;
`endif

    always_comb begin
        sync1_d   = key_raw;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        press_d   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != db_q[k]) begin
                if (cnt_q[k] == CW'(DEB_CYCLES - 1)) begin
                    db_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
            press_d[k] = (db_prev_q[k] & ~db_q[k]) | rep_fire[k];
        end
    end

    assign inc_ev  = press_q[0];
    assign dec_ev  = press_q[1];
    assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

    // Load beats key events; simultaneous inc and dec cancel out.
    always_comb begin
        ones_d     = ones_q;
        tens_d     = tens_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                ones_d = load_val[3:0];
                tens_d = load_val[7:4];
            end else begin
                load_err_d = 1'b1;
            end
        end else if (inc_ev && dec_ev) begin
            ones_d = ones_q;
        end else if (inc_ev) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
            end else begin
                ones_d = 4'd0;
                if (tens_q < 4'd9) begin
                    tens_d = tens_q + 4'd1;
                end else begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end
            end
        end else if (dec_ev) begin
            if (ones_q > 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                if (tens_q > 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    tens_d = 4'd9;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            db_q       <= 2'b11;
            db_prev_q  <= 2'b11;
            press_q    <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            db_prev_q  <= db_prev_d;
            press_q    <= press_d;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_key_counter.sv
// Bench for bcd_key_counter: decimal reference model checked every cycle, directed literal checks, random stimulus.
module tb_bcd_key_counter;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic       key_inc_n = 1'b1;
    logic       key_dec_n = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap;
    logic       load_err;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bcd_key_counter #(
        .DEB_CYCLES(DEB)
`ifdef BCD_KEY_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES(8)
`endif
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (RESET_N),
        .key_inc_n(key_inc_n),
        .key_dec_n(key_dec_n),
        .load     (load),
        .load_val (load_val),
        .ones     (ones),
        .tens     (tens),
        .wrap     (wrap),
        .load_err (load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: count held as an integer 0..99; a key press is a run of DEB
    // samples (seen two clocks late) that differ from the accepted level.
    int m_count = 0;
    bit m_wrap = 0;
    bit m_err = 0;
    bit m_ok = 0;
    bit m_db [2];
    int m_run [2];
    bit m_dl0 [2];
    bit m_dl1 [2];
    bit m_p0 [2];
    bit m_p1 [2];

    always @(posedge clk) begin
        bit seen, fell, raw;
        bit ev [2];
        if (!RESET_N) begin
            m_count = 0; m_wrap = 0; m_err = 0; m_ok = 1;
            for (int k = 0; k < 2; k++) begin
                m_db[k] = 1; m_run[k] = 0; m_dl0[k] = 1; m_dl1[k] = 1;
                m_p0[k] = 0; m_p1[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                raw = (k == 0) ? key_inc_n : key_dec_n;
                ev[k] = m_p1[k];
                seen = m_dl1[k];
                m_dl1[k] = m_dl0[k];
                m_dl0[k] = raw;
                fell = 0;
                if (seen == m_db[k]) m_run[k] = 0;
                else begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        fell = (seen == 0);
                        m_db[k] = seen;
                        m_run[k] = 0;
                    end
                end
                m_p1[k] = m_p0[k];
                m_p0[k] = fell;
            end
            m_wrap = 0; m_err = 0;
            if (load) begin
                if (load_val[7:4] <= 9 && load_val[3:0] <= 9)
                    m_count = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
                else m_err = 1;
            end else if (ev[0] && ev[1]) begin
                m_count = m_count;
            end else if (ev[0]) begin
                m_wrap = (m_count == 99);
                m_count = (m_count + 1) % 100;
            end else if (ev[1]) begin
                m_wrap = (m_count == 0);
                m_count = (m_count + 99) % 100;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("ones", 32'(ones), 32'(m_count % 10));
            check("tens", 32'(tens), 32'(m_count / 10));
            check("wrap", 32'(wrap), 32'(m_wrap));
            check("load_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds one key (0 inc, 1 dec, 2 both) low for 8 samples, returns at the negedge after edge N+7.
    task automatic press(input int k);
        if (k != 1) key_inc_n = 1'b0;
        if (k != 0) key_dec_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
    endtask

    function automatic int dut_count();
        return int'(tens) * 10 + int'(ones);
    endfunction

    initial begin
        RESET_N = 1'b0;
        idle(2);
        RESET_N = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(dut_count()), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_err", 32'(load_err), 0);
        idle(3);

        // Long hold: update lands exactly 7 edges after the first low sample.
        key_inc_n = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("hold_before", 32'(dut_count()), 0);
        @(posedge clk);
        @(negedge clk);
        check("hold_at7", 32'(dut_count()), 1);
        check("model_at7", 32'(m_count), 1);
        repeat (12) @(posedge clk);
        #1;
        key_inc_n = 1'b1;
        idle(20);
        check("hold_release", 32'(dut_count()), 1);

        key_inc_n = 1'b0;
        idle(2);
        key_inc_n = 1'b1;
        idle(15);
        check("glitch", 32'(dut_count()), 1);

        do_load(8'h99);
        check("load99", 32'(dut_count()), 99);
        idle(1);
        press(0);
        check("wrap_up_cnt", 32'(dut_count()), 0);
        check("wrap_up", 32'(wrap), 1);
        @(negedge clk);
        check("wrap_up_end", 32'(wrap), 0);
        idle(12);
        press(1);
        check("wrap_dn_cnt", 32'(dut_count()), 99);
        check("wrap_dn", 32'(wrap), 1);
        check("model_wrap_dn", 32'(m_count), 99);
        idle(12);

        do_load(8'h3A);
        check("bad_load_cnt", 32'(dut_count()), 99);
        check("bad_load_err", 32'(load_err), 1);
        @(negedge clk);
        check("bad_load_end", 32'(load_err), 0);
        idle(1);
        do_load(8'h19);
        check("load19", 32'(dut_count()), 19);
        idle(1);
        press(0);
        check("inc_20", 32'(dut_count()), 20);
        idle(12);

        press(2);
        idle(12);
        check("both_keys", 32'(dut_count()), 20);

        // Reset two samples into a debounce, key released while in reset.
        key_inc_n = 1'b0;
        idle(4);
        RESET_N = 1'b0;
        idle(1);
        key_inc_n = 1'b1;
        idle(1);
        RESET_N = 1'b1;
        idle(15);
        check("rst_mid_deb", 32'(dut_count()), 0);

        // Key held through reset release yields one press.
        key_inc_n = 1'b0;
        RESET_N = 1'b0;
        idle(2);
        RESET_N = 1'b1;
        idle(7);
        key_inc_n = 1'b1;
        idle(15);
        check("held_thru_rst", 32'(dut_count()), 1);

        for (int s = 0; s < 300; s++) begin
            int len;
            int mode;
            len = $urandom_range(1, 12);
            mode = $urandom_range(0, 5);
            for (int c = 0; c < len; c++) begin
                key_inc_n = !(mode == 0 || mode == 2);
                key_dec_n = !(mode == 1 || mode == 2);
                load = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 1) == 1)
                    load_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                else
                    load_val = 8'($urandom);
                RESET_N = !(mode == 5 && c < 2);
                idle(1);
            end
            key_inc_n = 1'b1;
            key_dec_n = 1'b1;
            load = 1'b0;
            RESET_N = 1'b1;
            idle($urandom_range(0, 10));
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
